// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter: FSM state and latched request.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned BE_WIDTH   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } lc3b_arb_state;

  typedef struct packed {
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   byte_enable;
  } lc3b_mem_req;

  // A side asserting both read and write is serviced as a write.
  function automatic lc3b_mem_req make_req(
    input logic                  rd,
    input logic                  wr,
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [BE_WIDTH-1:0]   be
  );
    lc3b_mem_req req;
    req.read        = rd & ~wr;
    req.write       = wr;
    req.address     = addr;
    req.wdata       = wdata;
    req.byte_enable = be;
    return req;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Single-word memory port: requester drives strobes/address/data, responder returns resp/rdata.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic [BE_WIDTH-1:0]   byte_enable;
  logic                  resp;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output read, write, address, wdata, byte_enable,
    input  resp, rdata
  );

  modport slave (
    input  read, write, address, wdata, byte_enable,
    output resp, rdata
  );

endinterface

// File: rtl/mem_arbiter_arb_select.sv
// Grant policy: fixed D-over-I by default; MEM_ARBITER_RR_EN alternates on contention.
module mem_arbiter_arb_select (
  input  logic i_req_i,
  input  logic i_req_d,
`ifdef MEM_ARBITER_RR_EN
  input  logic i_last_grant_d,
`endif
  output logic o_grant_i_c,
  output logic o_grant_d_c
);

  always_comb begin
    o_grant_d_c = i_req_d;
    o_grant_i_c = i_req_i & ~i_req_d;
`ifdef MEM_ARBITER_RR_EN
    // On contention, the side that did not win last time goes first.
    if (i_req_i && i_req_d) begin
      o_grant_d_c = ~i_last_grant_d;
      o_grant_i_c = i_last_grant_d;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction- and data-side memory ports onto one physical port, one word at a time.
// Define MEM_ARBITER_RR_EN for round-robin arbitration instead of fixed D-over-I priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  i_mem,
  mem_arbiter_if.slave  d_mem,
  mem_arbiter_if.master pmem
);

  lc3b_arb_state r_state;
  lc3b_mem_req   r_req;
  logic          w_req_i;
  logic          w_req_d;
  logic          w_grant_i;
  logic          w_grant_d;

  assign w_req_i = i_mem.read | i_mem.write;
  assign w_req_d = d_mem.read | d_mem.write;

`ifdef MEM_ARBITER_RR_EN
  logic r_last_grant_d;
`endif

  mem_arbiter_arb_select u_arb_select (
    .i_req_i        (w_req_i),
    .i_req_d        (w_req_d),
`ifdef MEM_ARBITER_RR_EN
    .i_last_grant_d (r_last_grant_d),
`endif
    .o_grant_i_c    (w_grant_i),
    .o_grant_d_c    (w_grant_d)
  );

  // Grant FSM; the physical port is driven only from the request latched at grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_req   <= '0;
`ifdef MEM_ARBITER_RR_EN
      r_last_grant_d <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_req   <= make_req(d_mem.read, d_mem.write, d_mem.address,
                                d_mem.wdata, d_mem.byte_enable);
            r_state <= SERVE_D;
`ifdef MEM_ARBITER_RR_EN
            r_last_grant_d <= 1'b1;
`endif
          end else if (w_grant_i) begin
            r_req   <= make_req(i_mem.read, i_mem.write, i_mem.address,
                                i_mem.wdata, i_mem.byte_enable);
            r_state <= SERVE_I;
`ifdef MEM_ARBITER_RR_EN
            r_last_grant_d <= 1'b0;
`endif
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem.resp) begin
            r_state     <= IDLE;
            r_req.read  <= 1'b0;
            r_req.write <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pmem.read        = r_req.read;
  assign pmem.write       = r_req.write;
  assign pmem.address     = r_req.address;
  assign pmem.wdata       = r_req.wdata;
  assign pmem.byte_enable = r_req.byte_enable;

  // Completion is forwarded only to the granted side; pmem_resp while IDLE is dropped.
  assign i_mem.resp  = (r_state == SERVE_I) & pmem.resp;
  assign d_mem.resp  = (r_state == SERVE_D) & pmem.resp;
  assign i_mem.rdata = pmem.rdata;
  assign d_mem.rdata = pmem.rdata;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of cpu_datapath.
- Consumes its two memory ports (i_mem_*, d_mem_*) and serialises them onto one physical memory port (pmem_*).
- Runs one single-word transaction at a time.
- Grant FSM latches the winning request and returns the response only to the granted requester.

Parameters:
ADDR_WIDTH, 16, width of all address buses
DATA_WIDTH, 16, width of all data buses (lc3b_word)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
i_mem_read  input  1  instruction-side read request, level-held until i_mem_resp
i_mem_write  input  1  instruction-side write request
i_mem_address  input  ADDR_WIDTH  instruction-side address
i_mem_wdata  input  DATA_WIDTH  instruction-side write data
i_mem_byte_enable  input  2  instruction-side byte enables
i_mem_resp  output  1  one-cycle completion pulse to instruction side
i_mem_rdata  output  DATA_WIDTH  read data to instruction side
d_mem_read  input  1  data-side read request
d_mem_write  input  1  data-side write request
d_mem_address  input  ADDR_WIDTH  data-side address
d_mem_wdata  input  DATA_WIDTH  data-side write data
d_mem_byte_enable  input  2  data-side byte enables
d_mem_resp  output  1  one-cycle completion pulse to data side
d_mem_rdata  output  DATA_WIDTH  read data to data side
pmem_read  output  1  physical read strobe
pmem_write  output  1  physical write strobe
pmem_address  output  ADDR_WIDTH  physical address
pmem_wdata  output  DATA_WIDTH  physical write data
pmem_byte_enable  output  2  physical byte enables
pmem_resp  input  1  physical completion, one cycle
pmem_rdata  input  DATA_WIDTH  physical read data, valid with pmem_resp

Behaviour:
- Clock/reset: single clock clk; reset is asynchronous and active-high.
- FSM states:
  - IDLE, SERVE_I, SERVE_D.
  - Reset forces IDLE immediately.
- Reset values, registered outputs:
  - pmem_read = 0, pmem_write = 0.
  - pmem_address, pmem_wdata = 0; pmem_byte_enable = 2'b00.
- Reset values, combinational outputs: i_mem_resp = 0, d_mem_resp = 0.
- Request: a side requests when read|write is high. If read and write are both high, it is treated as a write.
- IDLE:
  - At the clock edge, if any request is present, select a winner (D has priority over I) and go to SERVE_D or SERVE_I.
  - On that edge, latch the winner's address, wdata, byte_enable and op.
  - pmem_read/pmem_write assert in the cycle after the request is first seen (one-cycle grant latency).
- SERVE_x:
  - pmem_* are driven only from the latched copy. Requester input changes mid-transaction are ignored.
  - Strobes stay high until pmem_resp.
- Completion:
  - In the cycle pmem_resp = 1, x_mem_resp = 1 combinationally, and x_mem_rdata = pmem_rdata.
  - On that edge: FSM -> IDLE, strobes deassert.
  - The non-granted side's resp stays 0 throughout.
- rdata outputs: i_mem_rdata and d_mem_rdata always mirror pmem_rdata. Only resp qualifies them.
- Turnaround:
  - There is one IDLE cycle between consecutive transactions.
  - A requester that keeps its request high after resp is re-arbitrated fresh. cpu_datapath ties i_mem_read high, so this is the normal case.
- pmem_resp while IDLE: ignored, and no resp is forwarded.
- Request withdrawn mid-transaction: the transaction still completes and the resp pulse is still issued.
- Reset mid-transaction: strobes drop asynchronously, no resp is issued, and the latched request is discarded.

Optional Feature:
- Macro: MEM_ARBITER_RR_EN.
- Defined:
  - Round-robin priority. A 1-bit last_grant register (reset value = I) is updated on every grant.
  - When both sides request in IDLE, the side not granted last wins.
- Undefined: fixed D-over-I priority. The last_grant register is not present.

Decomposition:
- Package lc3b_types gains:
  - enum lc3b_arb_state {IDLE, SERVE_I, SERVE_D};
  - lc3b_mem_req struct {read, write, address, wdata, byte_enable}, used for the latched request.
- One natural sub-module: arb_select. It is combinational: both request bits plus last_grant in, grant select out. It holds the priority/RR policy so the FSM is policy-agnostic.

Test Plan:
1. Reset asserted mid-transaction in SERVE_D with pmem_read high -> pmem_read drops the same cycle, no d_mem_resp, FSM IDLE after reset release.
2. Only i_mem_read, address 0x0040, memory responds after 3 cycles with 0x1234 -> pmem_read high cycles 1-3 with address 0x0040; i_mem_resp pulses once with rdata 0x1234.
3. i_mem_read and d_mem_write (addr 0x8000, wdata 0xBEEF, be 2'b01) asserted simultaneously, macro undefined -> D served first (pmem_write, 0x8000/0xBEEF/01), then one idle cycle, then I read; no cross-resp.
4. Both sides request continuously, macro defined -> grants alternate D, I, D, I over 4 transactions.
5. D request granted, then d_mem_address changed to 0x1111 the next cycle -> pmem_address holds the original value until pmem_resp.
6. pmem_resp pulsed while IDLE, no requests -> i_mem_resp and d_mem_resp remain 0; FSM stays IDLE.
